// File: rtl/chiplink_tx_arb.sv
// rtl/chiplink_tx_arb.sv - credit-gated round-robin arbiter for the ChipLink TX lane
// Grant is held for a whole packet; every accepted beat spends one link credit.
module chiplink_tx_arb #(
   parameter int NREQ    = 4,
   parameter int DW      = 32,
   parameter int CREDITS = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ-1:0]              req_last,
   input  logic [NREQ*DW-1:0]           req_data,
   output logic [NREQ-1:0]              req_ready,
   input  logic                         credit_return,
   output logic                         chiplink_tx_send,
   output logic [DW-1:0]                chiplink_tx_data,
   output logic [$clog2(NREQ)-1:0]      grant_id,
   output logic                         busy,
   output logic                         credit_err
);

   localparam int GW = $clog2(NREQ);
   localparam logic [7:0]    CRED_MAX = 8'(CREDITS);
   localparam logic [GW-1:0] LAST_IDX = GW'(NREQ - 1);

   typedef enum logic {IDLE, XFER} state_t;

   state_t          state, state_d;
   logic [GW-1:0]   rr_ptr;
   logic [7:0]      credits;
   logic [GW-1:0]   win_idx;
   logic            win_found;
   int              scan_idx;
   logic            accept;
   logic            last_beat;

   // First valid requester after the one served most recently
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         scan_idx = (int'(rr_ptr) + k) % NREQ;
         if (!win_found && req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx[GW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state == XFER && credits != 8'd0)
         req_ready[grant_id] = 1'b1;
   end

   assign accept    = |(req_ready & req_valid);
   assign last_beat = req_last[grant_id];
   assign busy      = (state == XFER);

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (win_found) state_d = XFER;
         XFER:    if (accept && last_beat) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr           <= LAST_IDX;
         grant_id         <= '0;
         credits          <= CRED_MAX;
         credit_err       <= 1'b0;
         chiplink_tx_send <= 1'b0;
         chiplink_tx_data <= '0;
      end else begin
         if (state == IDLE && win_found)
            grant_id <= win_idx;
         if (accept && last_beat)
            rr_ptr <= grant_id;

         chiplink_tx_send <= accept;
         chiplink_tx_data <= accept ? req_data[int'(grant_id)*DW +: DW] : '0;

         // Simultaneous return and consume cancel out
         if (accept && !credit_return) begin
            credits <= credits - 8'd1;
         end else if (credit_return && !accept) begin
            if (credits == CRED_MAX) credit_err <= 1'b1;
            else                     credits    <= credits + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_chiplink_tx_arb.sv
// tb/tb_chiplink_tx_arb.sv - directed self-checking bench for chiplink_tx_arb
module tb_chiplink_tx_arb;

   localparam int NREQ = 4;
   localparam int DW   = 32;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_last;
   logic [NREQ*DW-1:0]  req_data;
   logic                credit_return;

   logic [NREQ-1:0]     ready_a, ready_b;
   logic                send_a, send_b;
   logic [DW-1:0]       data_a, data_b;
   logic [1:0]          gid_a, gid_b;
   logic                busy_a, busy_b;
   logic                err_a, err_b;

   int passed = 0;
   int total  = 0;

   chiplink_tx_arb #(.NREQ(NREQ), .DW(DW), .CREDITS(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
      .req_data(req_data), .req_ready(ready_a), .credit_return(credit_return),
      .chiplink_tx_send(send_a), .chiplink_tx_data(data_a), .grant_id(gid_a),
      .busy(busy_a), .credit_err(err_a)
   );

   chiplink_tx_arb #(.NREQ(NREQ), .DW(DW), .CREDITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
      .req_data(req_data), .req_ready(ready_b), .credit_return(credit_return),
      .chiplink_tx_send(send_b), .chiplink_tx_data(data_b), .grant_id(gid_b),
      .busy(busy_b), .credit_err(err_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_beat(input int r, input logic [DW-1:0] d, input logic l);
      req_data[r*DW +: DW] = d;
      req_last[r]          = l;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; credit_return = 1'b0;
      req_valid[0] = 1'b1;
      cyc();
      chk("reset_ready", ready_a, 4'b0000);
      req_valid = '0;
      cyc();
      rst_n = 1'b1;

      // 1: idle after reset
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("idle_send", send_a, 0);
         chk("idle_data", data_a, 0);
         chk("idle_busy", busy_a, 0);
         chk("idle_ready", ready_a, 0);
      end
      chk("idle_credits", dut.credits, 16);
      chk("idle_err", err_a, 0);

      // 2: three-beat packet from req0
      req_valid[0] = 1'b1; set_beat(0, 32'h0000_00A0, 1'b0);
      cyc();
      chk("t2_grant", gid_a, 0);
      chk("t2_busy", busy_a, 1);
      chk("t2_ready", ready_a, 4'b0001);
      chk("t2_bubble_send", send_a, 0);
      cyc();
      chk("t2_send0", send_a, 1);
      chk("t2_data0", data_a, 32'hA0);
      set_beat(0, 32'h0000_00A1, 1'b0);
      cyc();
      chk("t2_data1", data_a, 32'hA1);
      set_beat(0, 32'h0000_00A2, 1'b1);
      cyc();
      chk("t2_send2", send_a, 1);
      chk("t2_data2", data_a, 32'hA2);
      chk("t2_idle_busy", busy_a, 0);
      req_valid = '0; req_last = '0;
      cyc();
      chk("t2_send_off", send_a, 0);
      chk("t2_data_off", data_a, 0);
      chk("t2_credits", dut.credits, 13);

      // 3: all four requesters, single-beat packets
      do_reset();
      for (int r = 0; r < NREQ; r++) set_beat(r, 32'h100 + r, 1'b1);
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("t3_grant", gid_a, k % 4);
         chk("t3_bubble", send_a, 0);
         cyc();
         chk("t3_send", send_a, 1);
         chk("t3_data", data_a, 32'h100 + (k % 4));
         chk("t3_busy", busy_a, 0);
      end
      req_valid = '0; req_last = '0;
      cyc();
      chk("t3_credits", dut.credits, 11);

      // 4: credit starvation on a CREDITS=2 instance
      do_reset();
      chk("t4_credits_init", dut2.credits, 2);
      req_valid[1] = 1'b1; set_beat(1, 32'hB0, 1'b0);
      cyc();
      chk("t4_grant", gid_b, 1);
      chk("t4_ready", ready_b, 4'b0010);
      cyc();
      chk("t4_data0", data_b, 32'hB0);
      set_beat(1, 32'hB1, 1'b0);
      cyc();
      chk("t4_data1", data_b, 32'hB1);
      chk("t4_ready_zero", ready_b, 0);
      set_beat(1, 32'hB2, 1'b0);
      cyc();
      chk("t4_stall_send", send_b, 0);
      chk("t4_stall_data", data_b, 0);
      chk("t4_stall_grant", gid_b, 1);
      chk("t4_stall_busy", busy_b, 1);
      credit_return = 1'b1;
      cyc();
      credit_return = 1'b0;
      chk("t4_ready_back", ready_b, 4'b0010);
      chk("t4_credit_one", dut2.credits, 1);
      cyc();
      chk("t4_send2", send_b, 1);
      chk("t4_data2", data_b, 32'hB2);
      chk("t4_grant_held", gid_b, 1);
      chk("t4_no_err", err_b, 0);
      req_valid = '0;

      // 5: reset in the middle of a packet
      do_reset();
      req_valid[2] = 1'b1; set_beat(2, 32'hC0, 1'b0);
      cyc();
      chk("t5_grant2", gid_a, 2);
      cyc();
      chk("t5_send_c0", data_a, 32'hC0);
      req_valid[0] = 1'b1; set_beat(0, 32'hD0, 1'b1);
      rst_n = 1'b0;
      cyc();
      chk("t5_ready_in_reset", ready_a, 0);
      chk("t5_send_reset", send_a, 0);
      chk("t5_data_reset", data_a, 0);
      chk("t5_busy_reset", busy_a, 0);
      chk("t5_credits_reset", dut.credits, 16);
      rst_n = 1'b1;
      cyc();
      chk("t5_next_grant", gid_a, 0);
      chk("t5_busy", busy_a, 1);
      req_valid = '0; req_last = '0;

      // 6: credit return while counter full
      do_reset();
      credit_return = 1'b1;
      cyc();
      credit_return = 1'b0;
      chk("t6_credits", dut.credits, 16);
      chk("t6_err", err_a, 1);
      for (int i = 0; i < 3; i++) cyc();
      chk("t6_err_sticky", err_a, 1);
      chk("t6_send", send_a, 0);
      do_reset();
      cyc();
      chk("t6_err_cleared", err_a, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
